// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
//   Cleans the raw North-South and East-West pedestrian push-buttons into request
//   levels for the traffic controller. Each channel runs its own pipeline:
//     - a 2-flop synchroniser,
//     - a debouncer,
//     - rising-edge press detection,
//     - a request FSM (IDLE -> PENDING -> SERVED -> COOLDOWN),
//     - stuck-button detection.
//   The two channels share no state.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset (0 = reset)
//   btn_NS     in   raw NS push-button, asynchronous, active-high
//   btn_EW     in   raw EW push-button, asynchronous, active-high
//   served_NS  in   controller level: NS pedestrians are being served
//   served_EW  in   controller level: EW pedestrians are being served
//   ped_NS     out  latched NS request level (registered)
//   ped_EW     out  latched EW request level (registered)
//   stuck_NS   out  NS button stuck flag (registered)
//   stuck_EW   out  EW button stuck flag (registered)

module ped_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned COOLDOWN_CYCLES = 50000000,
  parameter int unsigned STUCK_CYCLES    = 1500000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_NS,
  input  logic btn_EW,
  input  logic served_NS,
  input  logic served_EW,
  output logic ped_NS,
  output logic ped_EW,
  output logic stuck_NS,
  output logic stuck_EW
);

  localparam int unsigned N_CH   = 2;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam int unsigned STK_W  = $clog2(STUCK_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [STK_W-1:0]  STK_MAX   = STK_W'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    SERVED   = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  // Channel 0 is NS, channel 1 is EW.
  logic [N_CH-1:0] btn_w;
  logic [N_CH-1:0] served_w;
  logic [N_CH-1:0] ped_w;
  logic [N_CH-1:0] stuck_w;

  assign btn_w    = {btn_EW, btn_NS};
  assign served_w = {served_EW, served_NS};

  assign ped_NS   = ped_w[0];
  assign ped_EW   = ped_w[1];
  assign stuck_NS = stuck_w[0];
  assign stuck_EW = stuck_w[1];

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

    logic              sync1_q;
    logic              sync2_q;
    logic              deb_q;
    logic              deb_d;
    logic              deb_dly_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_d;
    logic [STK_W-1:0]  stk_cnt_q;
    logic [STK_W-1:0]  stk_cnt_d;
    logic              stuck_q;
    logic              stuck_d;
    logic [COOL_W-1:0] cool_cnt_q;
    logic [COOL_W-1:0] cool_cnt_d;
    state_e            state_q;
    state_e            state_d;
    logic              ped_q;
    logic              ped_d;
    logic              press_c;

    // Two-flop synchroniser for the asynchronous button; only sync2_q is used.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_w[ch];
        sync2_q <= sync1_q;
      end
    end

    // Debounce: the level only follows sync2_q after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_d = sync2_q;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    end

    // Stuck detection: saturating count of cycles with the debounced level high.
    // The flag follows the next debounced level so it drops on the same edge
    // the debounced level returns to 0.
    always_comb begin
      stk_cnt_d = '0;
      if (deb_q) begin
        stk_cnt_d = (stk_cnt_q == STK_MAX) ? stk_cnt_q : stk_cnt_q + STK_W'(1);
      end
      stuck_d = deb_d && (stk_cnt_d == STK_MAX);
    end

    // Cooldown timer runs only while in COOLDOWN; it reads 0 on entry.
    always_comb begin
      cool_cnt_d = '0;
      if (state_q == COOLDOWN) begin
        cool_cnt_d = cool_cnt_q + COOL_W'(1);
      end
    end

    // Single-cycle press event on the debounced rising edge.
    assign press_c = deb_q & ~deb_dly_q;

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deb_q      <= 1'b0;
        deb_dly_q  <= 1'b0;
        deb_cnt_q  <= '0;
        stk_cnt_q  <= '0;
        stuck_q    <= 1'b0;
        cool_cnt_q <= '0;
      end else begin
        deb_q      <= deb_d;
        deb_dly_q  <= deb_q;
        deb_cnt_q  <= deb_cnt_d;
        stk_cnt_q  <= stk_cnt_d;
        stuck_q    <= stuck_d;
        cool_cnt_q <= cool_cnt_d;
      end
    end

    // FSM state register, with the registered request output.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        ped_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ped_q   <= ped_d;
      end
    end

    // FSM next state. A stuck flag rising while PENDING withdraws the request;
    // presses outside IDLE are dropped.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: begin
          if (press_c && !stuck_q) begin
            state_d = PENDING;
          end
        end
        PENDING: begin
          if (stuck_d) begin
            state_d = IDLE;
          end else if (served_w[ch]) begin
            state_d = SERVED;
          end
        end
        SERVED: begin
          if (!served_w[ch]) begin
            state_d = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cool_cnt_q == COOL_LAST) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // FSM output decode, taken from the next state so ped_q tracks state_q.
    always_comb begin
      ped_d = 1'b0;
      if (state_d == PENDING) begin
        ped_d = 1'b1;
      end
    end

    assign ped_w[ch]   = ped_q;
    assign stuck_w[ch] = stuck_q;

  end

endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb_ped_request_conditioner
//   Self-checking bench for ped_request_conditioner with DEBOUNCE_CYCLES=4,
//   COOLDOWN_CYCLES=8 and STUCK_CYCLES=32. Each table entry drives all inputs,
//   waits a number of clock edges and then checks all four outputs.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_ped_request_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned COOL = 8;
  localparam int unsigned STK  = 32;

  logic clk;
  logic rst;
  logic btn_NS;
  logic btn_EW;
  logic served_NS;
  logic served_EW;
  logic ped_NS;
  logic ped_EW;
  logic stuck_NS;
  logic stuck_EW;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .COOLDOWN_CYCLES(COOL),
    .STUCK_CYCLES   (STK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_NS   (btn_NS),
    .btn_EW   (btn_EW),
    .served_NS(served_NS),
    .served_EW(served_EW),
    .ped_NS   (ped_NS),
    .ped_EW   (ped_EW),
    .stuck_NS (stuck_NS),
    .stuck_EW (stuck_EW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stim = {rst, btn_NS, btn_EW, served_NS, served_EW}
  // expv = {ped_NS, ped_EW, stuck_NS, stuck_EW}
  typedef struct {
    string       name;
    logic [4:0]  stim;
    int unsigned wait_edges;
    logic [3:0]  expv;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] expv;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks;
  int   n_pass;
  int   split;

  function automatic void add(input string name, input logic [4:0] stim,
                              input int unsigned w, input logic [3:0] expv);
    vec_t v;
    v.name       = name;
    v.stim       = stim;
    v.wait_edges = w;
    v.expv       = expv;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [4:0] stim);
    {rst, btn_NS, btn_EW, served_NS, served_EW} = stim;
  endtask

  task automatic push_exp(input string name, input logic [3:0] expv);
    sb_t e;
    e.name = name;
    e.expv = expv;
    sb_q.push_back(e);
  endtask

  task automatic compare();
    sb_t        e;
    logic [3:0] act;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
    end else begin
      e   = sb_q.pop_front();
      act = {ped_NS, ped_EW, stuck_NS, stuck_EW};
      if (act === e.expv) begin
        n_pass++;
      end else begin
        $display("FAIL %s: {ped_NS,ped_EW,stuck_NS,stuck_EW} got %b expected %b at time %0t",
                 e.name, act, e.expv, $time);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.stim);
    push_exp(v.name, v.expv);
    repeat (v.wait_edges) @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset held with the NS button pressed and NS being served.
    add("rst_hold_a",     5'b0_1_0_1_0, 3,  4'b0000);
    add("rst_hold_b",     5'b0_1_0_1_0, 1,  4'b0000);
    // Release reset with the button still held: ped_NS exactly 7 edges later.
    add("rst_rel_e6",     5'b1_1_0_0_0, 6,  4'b0000);
    add("rst_rel_e7",     5'b1_1_0_0_0, 1,  4'b1000);
    add("ns_release",     5'b1_0_0_0_0, 6,  4'b1000);
    // Service drops the request on the next edge, then cooldown.
    add("ns_serve",       5'b1_0_0_1_0, 1,  4'b0000);
    add("ns_unserve",     5'b1_0_0_0_0, 1,  4'b0000);
    add("cool_press",     5'b1_1_0_0_0, 8,  4'b0000);
    add("cool_release",   5'b1_0_0_0_0, 7,  4'b0000);
    add("post_cool_e6",   5'b1_1_0_0_0, 6,  4'b0000);
    add("post_cool_e7",   5'b1_1_0_0_0, 1,  4'b1000);
    add("ns_release2",    5'b1_0_0_0_0, 6,  4'b1000);
    add("ns_serve2",      5'b1_0_0_1_0, 1,  4'b0000);
    add("ns_unserve2",    5'b1_0_0_0_0, 9,  4'b0000);
    // Bounce 1,0,1,1,0 then a stable rise.
    add("bounce0",        5'b1_1_0_0_0, 1,  4'b0000);
    add("bounce1",        5'b1_0_0_0_0, 1,  4'b0000);
    add("bounce2",        5'b1_1_0_0_0, 1,  4'b0000);
    add("bounce3",        5'b1_1_0_0_0, 1,  4'b0000);
    add("bounce4",        5'b1_0_0_0_0, 1,  4'b0000);
    add("bounce_hold_e6", 5'b1_1_0_0_0, 6,  4'b0000);
    add("bounce_hold_e7", 5'b1_1_0_0_0, 1,  4'b1000);
    add("ns_release3",    5'b1_0_0_0_0, 6,  4'b1000);
    add("ns_serve3",      5'b1_0_0_1_0, 1,  4'b0000);
    add("ns_unserve3",    5'b1_0_0_0_0, 9,  4'b0000);
    // Both channels pressed together, then only EW served.
    add("par_e6",         5'b1_1_1_0_0, 6,  4'b0000);
    add("par_e7",         5'b1_1_1_0_0, 1,  4'b1100);
    add("par_release",    5'b1_0_0_0_0, 6,  4'b1100);
    add("ew_serve",       5'b1_0_0_0_1, 1,  4'b1000);
    add("ew_unserve",     5'b1_0_0_0_0, 9,  4'b1000);
    // EW held: request, then stuck after 32 debounced-high cycles.
    add("stk_e6",         5'b1_0_1_0_0, 6,  4'b1000);
    add("stk_e7",         5'b1_0_1_0_0, 1,  4'b1100);
    add("stk_pre",        5'b1_0_1_0_0, 30, 4'b1100);
    add("stk_hit",        5'b1_0_1_0_0, 1,  4'b1001);
    add("stk_sat",        5'b1_0_1_0_0, 5,  4'b1001);
    add("stk_rel_e5",     5'b1_0_0_0_0, 5,  4'b1001);
    add("stk_rel_e6",     5'b1_0_0_0_0, 1,  4'b1000);
    add("stk_new_e6",     5'b1_0_1_0_0, 6,  4'b1000);
    add("stk_new_e7",     5'b1_0_1_0_0, 1,  4'b1100);
    split = vecs.size();
    // After the mid-cycle reset: a press while already served gives a 1-cycle pulse.
    add("srv_first_e6",   5'b1_1_0_1_0, 6,  4'b0000);
    add("srv_first_e7",   5'b1_1_0_1_0, 1,  4'b1000);
    add("srv_first_e8",   5'b1_1_0_1_0, 1,  4'b0000);

    drive(5'b0_1_0_1_0);

    for (int i = 0; i < split; i++) begin
      run_vec(vecs[i]);
    end

    // Reset asserted between clock edges while both requests are pending.
    #2;
    rst    = 1'b0;
    btn_EW = 1'b0;
    push_exp("async_rst_drop", 4'b0000);
    #1;
    compare();
    repeat (2) @(posedge clk);
    #1;
    push_exp("async_rst_held", 4'b0000);
    compare();

    for (int i = split; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
